// File: rtl/seg_display_scanner_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
// Segment codes are {g,f,e,d,c,b,a}, active-low (common anode).
package seg_display_scanner_pkg;

    localparam logic [6:0] SEG_D0    = 7'b1000000;
    localparam logic [6:0] SEG_D1    = 7'b1111001;
    localparam logic [6:0] SEG_D2    = 7'b0100100;
    localparam logic [6:0] SEG_D3    = 7'b0110000;
    localparam logic [6:0] SEG_D4    = 7'b0011001;
    localparam logic [6:0] SEG_D5    = 7'b0010010;
    localparam logic [6:0] SEG_D6    = 7'b0000010;
    localparam logic [6:0] SEG_D7    = 7'b1111000;
    localparam logic [6:0] SEG_D8    = 7'b0000000;
    localparam logic [6:0] SEG_D9    = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/seg_display_scanner_if.sv
// Load/busy handshake carrying the signed value to be displayed.
// The producer drives value/load; the scanner reports busy.
interface seg_display_scanner_if #(
    parameter int W = 16
) ();
    logic [W-1:0] value;
    logic         load;
    logic         busy;

    modport master (output value, output load, input busy);
    modport slave  (input value, input load, output busy);
endinterface

// File: rtl/seg_display_scanner_seg7_decode.sv
// Combinational digit/minus/blank to active-low segment pattern.
// Blank wins over minus, minus wins over the BCD code.
module seg7_decode
    import seg_display_scanner_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       blank_i,
    input  logic       minus_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else if (minus_i) begin
            seg_o = SEG_MINUS;
        end else begin
            case (code_i)
                4'd0:    seg_o = SEG_D0;
                4'd1:    seg_o = SEG_D1;
                4'd2:    seg_o = SEG_D2;
                4'd3:    seg_o = SEG_D3;
                4'd4:    seg_o = SEG_D4;
                4'd5:    seg_o = SEG_D5;
                4'd6:    seg_o = SEG_D6;
                4'd7:    seg_o = SEG_D7;
                4'd8:    seg_o = SEG_D8;
                4'd9:    seg_o = SEG_D9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Signed value to BCD (sequential double-dabble) and multiplexed
// 7-segment scan with sign and leading-zero blanking.
module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int W      = 16,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_clk,
    seg_display_scanner_if.slave  bus,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int NBCD = ((W - 1) * 30103) / 100000 + 1;
    localparam int NB   = NBCD * 4;
    localparam int IW   = $clog2(DIGITS);
    localparam int CW   = $clog2(W);

    logic              sync1_q, sync2_q, prev_q;
    logic              tick;
    logic              en_q;
    logic [IW-1:0]     idx_q, idx_nx;
    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q, seg_nx;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [NB-1:0]     bcd_q, bcd_d, bcd_adj;
    logic              sign_q, sign_d;
    logic [NB-1:0]     dsp_bcd_q, dsp_bcd_d;
    logic              dsp_sign_q, dsp_sign_d;

    logic              nz;
    logic [IW-1:0]     m;
    logic [3:0]        code;
    logic              show_num, minus_sel, blank_sel;

    assign tick    = sync2_q & ~prev_q;
    assign bus.busy = (state_q != IDLE);
    assign dp      = 1'b1;
    assign an      = an_q;
    assign seg     = seg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= scan_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // The first tick after reset lights digit 0; later ticks advance.
    always_comb begin
        idx_nx = '0;
        if (en_q) begin
            idx_nx = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        nz   = |dsp_bcd_q;
        m    = '0;
        code = '0;
        for (int i = 0; i < NBCD; i++) begin
            if (dsp_bcd_q[i*4 +: 4] != 4'd0) m = IW'(i);
            if (idx_nx == IW'(i)) code = dsp_bcd_q[i*4 +: 4];
        end
        show_num  = (idx_nx <= m);
        minus_sel = !show_num && dsp_sign_q && nz
                    && (idx_nx == m + IW'(1));
        blank_sel = !show_num && !minus_sel;
    end

    seg7_decode u_dec (
        .code_i  (code),
        .blank_i (blank_sel),
        .minus_i (minus_sel),
        .seg_o   (seg_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q  <= 1'b0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else if (tick) begin
            en_q  <= 1'b1;
            idx_q <= idx_nx;
            an_q  <= ~(DIGITS'(1) << idx_nx);
            seg_q <= seg_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            dsp_bcd_q  <= '0;
            dsp_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            dsp_bcd_q  <= dsp_bcd_d;
            dsp_sign_q <= dsp_sign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        dsp_bcd_d  = dsp_bcd_q;
        dsp_sign_d = dsp_sign_q;
        bcd_adj    = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    sign_d  = bus.value[W-1];
                    mag_d   = bus.value[W-1] ? (~bus.value + 1'b1)
                                             : bus.value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < NBCD; i++) begin
                    if (bcd_adj[i*4 +: 4] >= 4'd5)
                        bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
                end
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) state_d = DONE;
            end
            DONE: begin
                dsp_bcd_d  = bcd_q;
                dsp_sign_d = sign_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: vector table of values and expected
// display frames, scoreboard queue of frames checked by scanning.
module tb_seg_display_scanner;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'h7F;

    typedef logic [7:0][6:0] frame_t;
    typedef struct {
        logic [15:0] value;
        frame_t      exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       scan_clk;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;

    int checks;
    int failures;
    frame_t sb_q[$];
    vec_t   vecs[7];

    seg_display_scanner_if #(.W(16)) bus ();

    seg_display_scanner #(.W(16), .DIGITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_clk (scan_clk),
        .bus      (bus),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic scan_tick(output logic [7:0] a, output logic [6:0] s);
        @(negedge clk);
        scan_clk = 1'b1;
        repeat (3) @(negedge clk);
        a = an;
        s = seg;
        scan_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        frame_t     e;
        frame_t     f;
        logic [7:0] seen;
        logic [7:0] a;
        logic [6:0] s;
        logic [7:0] onehot;
        f    = '1;
        seen = '0;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        for (int k = 0; k < 8; k++) begin
            scan_tick(a, s);
            for (int i = 0; i < 8; i++) begin
                onehot = 8'd1 << i;
                if (a == ~onehot) begin
                    seen[i] = 1'b1;
                    f[i]    = s;
                end
            end
            chk({tag, "_dp"}, {31'd0, dp}, 32'd1);
        end
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("%s_seen%0d", tag, d), {31'd0, seen[d]}, 32'd1);
            chk($sformatf("%s_d%0d", tag, d), {25'd0, f[d]}, {25'd0, e[d]});
        end
    endtask

    task automatic wait_idle(input string tag, output int bc);
        bc = 0;
        while (bus.busy === 1'b1 && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        if (bc >= 100) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic convert(input logic [15:0] v, input string tag,
                           output int bc);
        @(negedge clk);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        wait_idle(tag, bc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bc;
        logic [7:0] a;
        logic [6:0] s;
        logic [7:0] an_hold;
        int         n;

        checks   = 0;
        failures = 0;

        vecs[0] = '{16'd1234,  {SB, SB, SB, SB, S1, S2, S3, S4}};
        vecs[1] = '{16'hC000,  {SB, SB, SM, S1, S6, S3, S8, S4}};
        vecs[2] = '{16'h8000,  {SB, SB, SM, S3, S2, S7, S6, S8}};
        vecs[3] = '{16'd0,     {SB, SB, SB, SB, SB, SB, SB, S0}};
        vecs[4] = '{16'd32767, {SB, SB, SB, S3, S2, S7, S6, S7}};
        vecs[5] = '{16'hFFFF,  {SB, SB, SB, SB, SB, SB, SM, S1}};
        vecs[6] = '{16'd100,   {SB, SB, SB, SB, SB, S1, S0, S0}};

        rst       = 1'b0;
        scan_clk  = 1'b0;
        bus.load  = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_an",   {24'd0, an},  32'hFF);
        chk("rst_seg",  {25'd0, seg}, 32'h7F);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_dp",   {31'd0, dp},  32'd1);

        scan_clk = 1'b1;
        n = 0;
        while (an != 8'hFE && n < 3) begin
            @(negedge clk);
            n++;
        end
        chk("first_tick_an",  {24'd0, an},  32'hFE);
        chk("first_tick_seg", {25'd0, seg}, {25'd0, S0});
        scan_clk = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            convert(vecs[v].value, $sformatf("v%0d", v), bc);
            chk($sformatf("v%0d_busy_cycles", v), bc, 32'd17);
            sb_q.push_back(vecs[v].exp);
            check_frame($sformatf("v%0d", v));
        end

        // second load during conversion must be ignored
        @(negedge clk);
        bus.value = 16'd5;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bc = 0;
        while (bus.busy === 1'b1 && bc < 100) begin
            bc++;
            if (bc == 5) begin
                bus.value = 16'd9;
                bus.load  = 1'b1;
            end else begin
                bus.load  = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk("ign_busy_cycles", bc, 32'd17);
        sb_q.push_back({SB, SB, SB, SB, SB, SB, SB, S5});
        check_frame("ign");

        // load in the first idle cycle after DONE is accepted
        convert(16'd7, "b2b_a", bc);
        bus.value = 16'd100;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle("b2b_b", bc);
        chk("b2b_busy_cycles", bc, 32'd17);
        sb_q.push_back({SB, SB, SB, SB, SB, S1, S0, S0});
        check_frame("b2b");

        // reset in the middle of a conversion
        @(negedge clk);
        bus.value = 16'd999;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_an",   {24'd0, an},  32'hFF);
        chk("mid_rst_seg",  {25'd0, seg}, 32'h7F);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_idle_busy", {31'd0, bus.busy}, 32'd0);
        sb_q.push_back({SB, SB, SB, SB, SB, SB, SB, S0});
        check_frame("mid");

        // scan_clk held high gives one tick only
        scan_tick(a, s);
        @(negedge clk);
        scan_clk = 1'b1;
        repeat (3) @(negedge clk);
        an_hold = an;
        repeat (100) @(negedge clk);
        chk("hold_hi_an", {24'd0, an}, {24'd0, an_hold});
        chk("hold_hi_moved", {31'd0, (an_hold != a)}, 32'd1);
        scan_clk = 1'b0;
        repeat (3) @(negedge clk);
        an_hold = an;
        repeat (50) @(negedge clk);
        chk("hold_lo_an", {24'd0, an}, {24'd0, an_hold});

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
